// File: rtl/i2s_rx_frame_capture.sv
// Multi-lane I2S (Philips timing) receiver that assembles left/right word pairs
// into frames and hands them out through a valid/ready register with overrun counting.
module i2s_rx_frame_capture #(
  parameter int DATA_W = 16,
  parameter int LANES  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sck,
  input  logic                    ws,
  input  logic [LANES-1:0]        sd,
  output logic [LANES*DATA_W-1:0] frame_left,
  output logic [LANES*DATA_W-1:0] frame_right,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun,
  output logic [7:0]              overrun_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;
  typedef logic [LANES-1:0][DATA_W-1:0] words_t;

  logic             sck_s1_q, sck_s2_q, sck_s3_q, sck_s1_d, sck_s2_d, sck_s3_d;
  logic             ws_s1_q, ws_s2_q, ws_s1_d, ws_s2_d;
  logic [LANES-1:0] sd_s1_q, sd_s2_q, sd_s1_d, sd_s2_d;
  logic             ws_q, ws_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  words_t           shift_q, shift_d, shift_ins;
  words_t           hold_q, hold_d;
  words_t           frame_left_q, frame_left_d, frame_right_q, frame_right_d;
  logic             frame_valid_q, frame_valid_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       overrun_cnt_q, overrun_cnt_d;
  state_t           state_q, state_d;
  logic             sck_rise, ws_edge, latch_left, frame_done, load;

  // Synchronizers, sck edge detect and per-lane slot shifting
  always_comb begin
    sck_s1_d = sck;
    sck_s2_d = sck_s1_q;
    sck_s3_d = sck_s2_q;
    ws_s1_d  = ws;
    ws_s2_d  = ws_s1_q;
    sd_s1_d  = sd;
    sd_s2_d  = sd_s1_q;
    sck_rise = sck_s2_q & ~sck_s3_q;
    ws_edge  = sck_rise & (ws_s2_q != ws_q);
    ws_d     = sck_rise ? ws_s2_q : ws_q;
    // The bit sampled now lands at DATA_W-1-count; once the count saturates it is dropped.
    shift_ins = shift_q;
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (bit_cnt_q == CNT_W'(DATA_W - 1 - b)) shift_ins[l][b] = sd_s2_q[l];
      end
    end
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (!en || ws_edge) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (sck_rise) begin
      shift_d = shift_ins;
      if (bit_cnt_q != CNT_W'(DATA_W)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
  end

  // Slot FSM: the word completing at a ws_edge belongs to the state being left
  always_comb begin
    state_d    = state_q;
    latch_left = 1'b0;
    frame_done = 1'b0;
    if (!en) begin
      state_d = HUNT;
    end else if (ws_edge) begin
      case (state_q)
        HUNT:    if (!ws_s2_q) state_d = LEFT;
        LEFT: begin
          state_d    = RIGHT;
          latch_left = 1'b1;
        end
        RIGHT: begin
          state_d    = LEFT;
          frame_done = 1'b1;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Output register with valid/ready handshake and saturating drop counter
  always_comb begin
    hold_d        = latch_left ? shift_ins : hold_q;
    load          = frame_done & (~frame_valid_q | frame_ready);
    frame_left_d  = frame_left_q;
    frame_right_d = frame_right_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = 1'b0;
    overrun_cnt_d = overrun_cnt_q;
    if (load) begin
      frame_left_d  = hold_q;
      frame_right_d = shift_ins;
      frame_valid_d = 1'b1;
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
    if (frame_done && !load) begin
      overrun_d = 1'b1;
      if (overrun_cnt_q != 8'hFF) overrun_cnt_d = overrun_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1_q      <= 1'b0;
      sck_s2_q      <= 1'b0;
      sck_s3_q      <= 1'b0;
      ws_s1_q       <= 1'b0;
      ws_s2_q       <= 1'b0;
      sd_s1_q       <= '0;
      sd_s2_q       <= '0;
      ws_q          <= 1'b0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      hold_q        <= '0;
      frame_left_q  <= '0;
      frame_right_q <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
      state_q       <= HUNT;
    end else begin
      sck_s1_q      <= sck_s1_d;
      sck_s2_q      <= sck_s2_d;
      sck_s3_q      <= sck_s3_d;
      ws_s1_q       <= ws_s1_d;
      ws_s2_q       <= ws_s2_d;
      sd_s1_q       <= sd_s1_d;
      sd_s2_q       <= sd_s2_d;
      ws_q          <= ws_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      frame_left_q  <= frame_left_d;
      frame_right_q <= frame_right_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
      state_q       <= state_d;
    end
  end

  assign frame_left  = frame_left_q;
  assign frame_right = frame_right_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_i2s_rx_frame_capture.sv
// Directed bench for i2s_rx_frame_capture: drives Philips-format I2S on three lanes
// and checks captured frames, back-pressure, overrun, reset and enable behaviour.
module tb_i2s_rx_frame_capture;

  localparam int DW = 16;
  localparam int LN = 3;

  logic             clk, rst, en, sck, ws, frame_ready;
  logic [LN-1:0]    sd;
  logic [LN*DW-1:0] frame_left, frame_right;
  logic             frame_valid, overrun;
  logic [7:0]       overrun_cnt;

  int checks = 0;
  int errors = 0;
  int cap_cnt = 0;
  int ovr_pulses = 0;
  int base;
  int obase;
  logic [LN*DW-1:0] cap_left, cap_right;

  i2s_rx_frame_capture #(.DATA_W(DW), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .en(en), .sck(sck), .ws(ws), .sd(sd),
    .frame_left(frame_left), .frame_right(frame_right),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted frame and every overrun pulse
  always @(negedge clk) begin
    if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
      cap_cnt   <= cap_cnt + 1;
      cap_left  <= frame_left;
      cap_right <= frame_right;
    end
    if (overrun === 1'b1) ovr_pulses <= ovr_pulses + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter changes ws/sd while sck is low; receiver samples on the rise.
  task automatic send_bit(input logic w, input logic [LN-1:0] d);
    sck = 1'b0;
    ws  = w;
    sd  = d;
    #40;
    sck = 1'b1;
    #40;
  endtask

  // Bits k0..k1-1 of an n-bit slot; ws flips one bit early (Philips timing).
  task automatic send_range(input logic w, input logic [LN*DW-1:0] words,
                            input int k0, input int k1, input int n);
    for (int k = k0; k < k1; k++) begin
      logic [LN-1:0] d;
      d = '0;
      for (int l = 0; l < LN; l++) begin
        if (k < DW) d[l] = words[l*DW + DW - 1 - k];
      end
      send_bit((k == n - 1) ? ~w : w, d);
    end
  endtask

  task automatic send_slot(input logic w, input logic [LN*DW-1:0] words, input int n);
    send_range(w, words, 0, n, n);
  endtask

  task automatic send_frame(input logic [LN*DW-1:0] l, input logic [LN*DW-1:0] r, input int n);
    send_slot(1'b0, l, n);
    send_slot(1'b1, r, n);
  endtask

  task automatic wait_cap(input int target, input string tag);
    for (int i = 0; i < 3000 && cap_cnt < target; i++) @(negedge clk);
    check(tag, cap_cnt, target);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 3000 && frame_valid !== 1'b1; i++) @(negedge clk);
    check(tag, frame_valid, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sck = 1'b0; ws = 1'b0; sd = '0; frame_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", frame_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_cnt", overrun_cnt, 0);
    check("rst_left", frame_left, 0);
    check("rst_right", frame_right, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;

    // 32-bit slots, ready held high
    send_slot(1'b1, '0, 32);
    send_frame(48'hFFFF_0001_A5A5, 48'h0000_8000_1234, 32);
    wait_cap(1, "f32a_count");
    check("f32a_left", cap_left, 48'hFFFF_0001_A5A5);
    check("f32a_right", cap_right, 48'h0000_8000_1234);
    send_frame(48'h0000_FFFF_1234, 48'hA5A5_0001_8000, 32);
    wait_cap(2, "f32b_count");
    check("f32b_left", cap_left, 48'h0000_FFFF_1234);
    check("f32b_right", cap_right, 48'hA5A5_0001_8000);
    check("f32_ovr_cnt", overrun_cnt, 0);

    // 16-bit slots then 12-bit slots
    send_frame(48'h3333_2222_1111, 48'h6666_5555_4444, 16);
    wait_cap(3, "f16_count");
    check("f16_left", cap_left, 48'h3333_2222_1111);
    check("f16_right", cap_right, 48'h6666_5555_4444);
    send_frame(48'h0000_5A50_ABC0, 48'h8010_FFF0_1230, 12);
    wait_cap(4, "f12_count");
    check("f12_left", cap_left, 48'h0000_5A50_ABC0);
    check("f12_right", cap_right, 48'h8010_FFF0_1230);

    // Back-pressure over three frames
    @(negedge clk);
    frame_ready = 1'b0;
    base  = cap_cnt;
    obase = ovr_pulses;
    send_frame(48'h1111_AAAA_0F0F, 48'h2222_BBBB_F0F0, 16);
    wait_valid("bp_first_valid");
    send_frame(48'h3333_CCCC_0000, 48'h4444_DDDD_0000, 16);
    send_frame(48'h5555_EEEE_FFFF, 48'h6666_9999_FFFF, 16);
    repeat (10) @(negedge clk);
    check("bp_valid", frame_valid, 1);
    check("bp_left_held", frame_left, 48'h1111_AAAA_0F0F);
    check("bp_right_held", frame_right, 48'h2222_BBBB_F0F0);
    check("bp_ovr_pulses", ovr_pulses - obase, 2);
    check("bp_ovr_cnt", overrun_cnt, 2);
    check("bp_no_accept", cap_cnt, base);
    frame_ready = 1'b1;
    wait_cap(base + 1, "bp_accept_count");
    check("bp_accept_left", cap_left, 48'h1111_AAAA_0F0F);
    repeat (2) @(negedge clk);
    check("bp_valid_clear", frame_valid, 0);

    // Reset in the middle of a right slot
    base = cap_cnt;
    send_slot(1'b0, 48'h0BAD_0BAD_0BAD, 16);
    send_range(1'b1, 48'h7777_7777_7777, 0, 6, 16);
    rst = 1'b1;
    #1;
    check("midrst_left", frame_left, 0);
    check("midrst_right", frame_right, 0);
    check("midrst_cnt", overrun_cnt, 0);
    check("midrst_valid", frame_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    send_range(1'b1, 48'h7777_7777_7777, 6, 16, 16);
    repeat (10) @(negedge clk);
    check("midrst_no_frame", cap_cnt, base);
    send_frame(48'hC0DE_BEEF_CAFE, 48'h0123_4567_89AB, 16);
    wait_cap(base + 1, "midrst_first_count");
    check("midrst_first_left", cap_left, 48'hC0DE_BEEF_CAFE);
    check("midrst_first_right", cap_right, 48'h0123_4567_89AB);

    // Disable for one frame with an output frame pending
    @(negedge clk);
    frame_ready = 1'b0;
    base = cap_cnt;
    send_frame(48'h1357_2468_ACE0, 48'h9BDF_8642_7531, 16);
    wait_valid("en_pending_valid");
    en = 1'b0;
    send_slot(1'b0, 48'hDEAD_DEAD_DEAD, 16);
    send_range(1'b1, 48'hFACE_FACE_FACE, 0, 8, 16);
    en = 1'b1;
    send_range(1'b1, 48'hFACE_FACE_FACE, 8, 16, 16);
    repeat (10) @(negedge clk);
    check("en_valid_kept", frame_valid, 1);
    check("en_left_kept", frame_left, 48'h1357_2468_ACE0);
    check("en_right_kept", frame_right, 48'h9BDF_8642_7531);
    check("en_no_accept", cap_cnt, base);
    check("en_no_overrun", overrun_cnt, 0);
    frame_ready = 1'b1;
    wait_cap(base + 1, "en_pending_count");
    check("en_pending_left", cap_left, 48'h1357_2468_ACE0);
    send_frame(48'h0F00_00F0_000F, 48'hF000_0F00_00F0, 16);
    wait_cap(base + 2, "en_resume_count");
    check("en_resume_left", cap_left, 48'h0F00_00F0_000F);
    check("en_resume_right", cap_right, 48'hF000_0F00_00F0);

    // 300 frames with no consumer: counter saturates
    @(negedge clk);
    frame_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 0) send_frame(48'hA000_B000_C000, 48'hD000_E000_F000, 4);
      else        send_frame(48'h5000_5000_5000, 48'h6000_6000_6000, 4);
      if (i == 99) begin
        repeat (6) @(negedge clk);
        check("sat_cnt_99", overrun_cnt, 99);
      end
    end
    repeat (10) @(negedge clk);
    check("sat_cnt_255", overrun_cnt, 255);
    check("sat_left_held", frame_left, 48'hA000_B000_C000);
    check("sat_right_held", frame_right, 48'hD000_E000_F000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
